wishbone_row_master: RTL and testbench
======================================

// Module: wishbone_row_master
// PURPOSE
//  Wishbone master that streams data-memory rows (X,Y,Z words) out to a Wishbone
//  slave port; the transmit-side counterpart of the Theia Wishbone slave unit.
//  Fetches a 3-word data row from local data memory and sends X, Y, Z as three
//  write strobes in one CYC_O cycle. Closes each row with a CYC_O low + MST_O commit
//  cycle. Sits between the Theia core's data memory and the system/peer Wishbone bus.
// PARAMETERS
//  WB_WIDTH     32  width of DAT_O / one row word
//  ADDR_WIDTH   16  width of ADR_O, iSrcAddress, iDstAddress, oDataReadAddress
//  COUNT_WIDTH  16  width of iRowCount
// PORTS
//  CLK_I             in   1            sole clock, rising edge
//  RST_I             in   1            asynchronous reset, active-low
//  iStart            in   1            1-cycle request; sampled only in IDLE
//  iSrcAddress       in   ADDR_WIDTH   first local data-memory row address
//  iDstAddress       in   ADDR_WIDTH   first destination row address on Wishbone
//  iRowCount         in   COUNT_WIDTH  rows to send; 0 = none
//  oDataReadAddress  out  ADDR_WIDTH   data-memory read address
//  iDataBus          in   3*WB_WIDTH   row {X,Y,Z}; valid 1 cycle after address
//  CYC_O             out  1            bus cycle, one per row
//  STB_O             out  1            strobe, one per word
//  WE_O              out  1            constant 1 while CYC_O=1, else 0
//  ADR_O             out  ADDR_WIDTH   row destination address
//  DAT_O             out  WB_WIDTH     current word
//  TGA_O             out  2            2'b01 (data-address tag) while CYC_O=1, else 0
//  MST_O             out  1            commit marker, high in COMMIT only
//  GNT_I             in   1            bus grant
//  ACK_I             in   1            slave acknowledge
//  ERR_I             in   1            slave error
//  oBusy             out  1            high in every state except IDLE
//  oDone             out  1            1-cycle pulse at end of transfer
//  oError            out  1            1-cycle pulse with oDone if aborted by ERR_I
// BEHAVIOUR
//  Reset (RST_I=0, async): state=IDLE. All outputs are 0, including DAT_O, ADR_O, oDataReadAddress,
//   TGA_O and the internal counters. A transfer in flight is dropped at once and not resumed.
//  IDLE: iStart&&iRowCount!=0 -> latch src/dst/count, go RD. iStart&&iRowCount==0 -> DONE
//   with no bus activity. iStart is ignored outside IDLE.
//  RD: oDataReadAddress=src; -> CAP.  CAP: register iDataBus into row reg; -> ARB.
//  ARB: CYC_O=1, ADR_O=dst, TGA_O=2'b01, word idx=0; wait GNT_I=1 -> WR.
//  WR: STB_O=1, DAT_O = X (idx0: [3W-1:2W]), Y (idx1: [2W-1:W]) or Z (idx2: [W-1:0]).
//   ACK_I=1 -> GAP. ERR_I=1 (has priority over ACK_I) -> ABORT.
//  GAP: STB_O=0 for exactly 1 cycle. Then: idx<2 -> idx++, WR; idx==2 -> COMMIT.
//  COMMIT: CYC_O=0, MST_O=1 for 1 cycle. Then src++, dst++, count--.
//   If count (after decrement)==0 -> DONE, else -> RD.
//  ABORT: CYC_O=0, STB_O=0, MST_O=0 (row not committed); -> DONE with oError=1.
//  DONE: oDone=1 for 1 cycle; -> IDLE.
//  ACK_I/ERR_I are ignored when STB_O=0. GNT_I loss during WR does not stall a strobe.
//  src/dst increment mod 2^ADDR_WIDTH (0xFFFF+1 -> 0x0000).
//  Latency, ACK one cycle after STB: RD, CAP, ARB(1 with GNT), 3x(WR 2 + GAP 1), COMMIT
//   = 13 cycles per row, plus 1 DONE cycle per transfer.
//  ADR_O/TGA_O stay stable for the whole CYC_O=1 window. DAT_O stays stable while STB_O=1.
// TESTING
//  1) src=0x0010, dst=0x0200, cnt=1, row=0x11111111_22222222_33333333, slave ACKs at +1
//     -> oDataReadAddress=0x0010. Three STB phases on ADR_O=0x0200 with DAT_O 0x11111111,
//     0x22222222, 0x33333333. Then 1 cycle CYC_O=0/MST_O=1, then oDone pulse, oError=0.
//  2) cnt=3, dst=0xFFFE -> three CYC_O windows with ADR_O 0xFFFE, 0xFFFF, 0x0000.
//     Three MST_O pulses, one oDone.
//  3) cnt=0 -> oDone 2 cycles after iStart; CYC_O/STB_O/MST_O never asserted.
//  4) GNT_I held low 5 cycles in ARB -> CYC_O=1, STB_O=0 throughout. STB_O rises the
//     cycle after GNT_I=1.
//  5) ERR_I on the Y strobe of row 0, cnt=2 -> CYC_O falls next cycle, no MST_O pulse,
//     row 1 never read. oDone and oError both pulse.
//  6) RST_I low mid-WR, plus iStart pulsed while busy -> all outputs 0 immediately on
//     reset; after release IDLE. A second iStart during a transfer changes nothing.

Source files
------------

// File: rtl/wishbone_row_master.sv
// Wishbone master that streams 3-word data-memory rows (X,Y,Z) to a slave port,
// one CYC_O window per row followed by a CYC_O-low commit cycle with MST_O high.
module wishbone_row_master #(
  parameter int unsigned WB_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    iStart,
  input  logic [ADDR_WIDTH-1:0]   iSrcAddress,
  input  logic [ADDR_WIDTH-1:0]   iDstAddress,
  input  logic [COUNT_WIDTH-1:0]  iRowCount,
  output logic [ADDR_WIDTH-1:0]   oDataReadAddress,
  input  logic [3*WB_WIDTH-1:0]   iDataBus,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    WE_O,
  output logic [ADDR_WIDTH-1:0]   ADR_O,
  output logic [WB_WIDTH-1:0]     DAT_O,
  output logic [1:0]              TGA_O,
  output logic                    MST_O,
  input  logic                    GNT_I,
  input  logic                    ACK_I,
  input  logic                    ERR_I,
  output logic                    oBusy,
  output logic                    oDone,
  output logic                    oError
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_ARB,
    S_WR,
    S_GAP,
    S_COMMIT,
    S_ABORT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [3*WB_WIDTH-1:0]   row_q, row_d;
  logic [1:0]              idx_q, idx_d;
  logic                    err_q, err_d;

  logic                    cyc;
  logic                    stb;
  logic [WB_WIDTH-1:0]     word;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    row_d   = row_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cyc     = 1'b0;
    stb     = 1'b0;
    MST_O   = 1'b0;
    oBusy   = 1'b1;
    oDone   = 1'b0;
    oError  = 1'b0;

    case (state_q)
      S_IDLE: begin
        oBusy = 1'b0;
        if (iStart) begin
          err_d = 1'b0;
          if (iRowCount != '0) begin
            src_d   = iSrcAddress;
            dst_d   = iDstAddress;
            count_d = iRowCount;
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        row_d   = iDataBus;
        state_d = S_ARB;
      end
      S_ARB: begin
        cyc   = 1'b1;
        idx_d = '0;
        if (GNT_I) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        // GNT_I is deliberately not looked at here: a started strobe runs to ACK/ERR.
        cyc = 1'b1;
        stb = 1'b1;
        if (ERR_I) begin
          state_d = S_ABORT;
        end else if (ACK_I) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cyc = 1'b1;
        if (idx_q == 2'd2) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_WR;
        end
      end
      S_COMMIT: begin
        MST_O   = 1'b1;
        src_d   = src_q + ADDR_WIDTH'(1);
        dst_d   = dst_q + ADDR_WIDTH'(1);
        count_d = count_q - COUNT_WIDTH'(1);
        state_d = (count_q == COUNT_WIDTH'(1)) ? S_DONE : S_RD;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        oDone   = 1'b1;
        oError  = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    word = row_q[3*WB_WIDTH-1:2*WB_WIDTH];
      2'd1:    word = row_q[2*WB_WIDTH-1:WB_WIDTH];
      default: word = row_q[WB_WIDTH-1:0];
    endcase
  end

  // Bus-facing fields are forced to zero outside their qualifying window.
  assign CYC_O            = cyc;
  assign STB_O            = stb;
  assign WE_O             = cyc;
  assign TGA_O            = cyc ? 2'b01 : 2'b00;
  assign ADR_O            = cyc ? dst_q : '0;
  assign DAT_O            = stb ? word : '0;
  assign oDataReadAddress = src_q;

endmodule

// File: tb/tb_wishbone_row_master.sv
// Randomized bench for wishbone_row_master: transaction-level row model versus
// writes collected by a behavioural Wishbone slave, plus protocol and timing checks.
module tb_wishbone_row_master;

  localparam int unsigned W = 32;
  localparam int unsigned A = 16;
  localparam int unsigned C = 16;

  logic             CLK_I = 1'b0;
  logic             RST_I = 1'b0;
  logic             iStart = 1'b0;
  logic [A-1:0]     iSrcAddress = '0;
  logic [A-1:0]     iDstAddress = '0;
  logic [C-1:0]     iRowCount = '0;
  logic [A-1:0]     oDataReadAddress;
  logic [3*W-1:0]   iDataBus = '0;
  logic             CYC_O, STB_O, WE_O, MST_O;
  logic [A-1:0]     ADR_O;
  logic [W-1:0]     DAT_O;
  logic [1:0]       TGA_O;
  logic             GNT_I = 1'b0;
  logic             ACK_I = 1'b0;
  logic             ERR_I = 1'b0;
  logic             oBusy, oDone, oError;

  wishbone_row_master #(
    .WB_WIDTH   (W),
    .ADDR_WIDTH (A),
    .COUNT_WIDTH(C)
  ) dut (
    .CLK_I           (CLK_I),
    .RST_I           (RST_I),
    .iStart          (iStart),
    .iSrcAddress     (iSrcAddress),
    .iDstAddress     (iDstAddress),
    .iRowCount       (iRowCount),
    .oDataReadAddress(oDataReadAddress),
    .iDataBus        (iDataBus),
    .CYC_O           (CYC_O),
    .STB_O           (STB_O),
    .WE_O            (WE_O),
    .ADR_O           (ADR_O),
    .DAT_O           (DAT_O),
    .TGA_O           (TGA_O),
    .MST_O           (MST_O),
    .GNT_I           (GNT_I),
    .ACK_I           (ACK_I),
    .ERR_I           (ERR_I),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oError          (oError)
  );

  always #5 CLK_I = ~CLK_I;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data memory: 64 rows, mirrored across the address space; one-cycle read latency.
  logic [3*W-1:0] mem [64];
  logic [A-1:0]   rd_lat;

  initial begin
    forever begin
      @(negedge CLK_I);
      rd_lat = oDataReadAddress;
      @(posedge CLK_I);
      #1 iDataBus = mem[rd_lat[5:0]];
    end
  end

  // Slave / arbiter behaviour
  int             err_at = -1;
  int             strobe_no = 0;
  bit             rnd_timing = 0;
  int             gnt_mode = 0;
  logic [A+W-1:0] obs_q[$];
  int             s_wait = 0;
  int             s_dly = 1;
  int             s_gwin = 0;

  initial begin
    forever begin
      @(negedge CLK_I);
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      s_gwin = CYC_O ? s_gwin + 1 : 0;
      case (gnt_mode)
        0:       GNT_I = 1'b1;
        1:       GNT_I = ($urandom_range(0, 3) != 0);
        default: GNT_I = (s_gwin > 5);
      endcase
      if (STB_O) begin
        s_wait++;
        if (s_wait > s_dly) begin
          if (strobe_no == err_at) ERR_I = 1'b1;
          else begin
            ACK_I = 1'b1;
            obs_q.push_back({ADR_O, DAT_O});
          end
          strobe_no++;
          s_wait = 0;
          s_dly  = rnd_timing ? int'($urandom_range(1, 3)) : 1;
        end
      end else begin
        s_wait = 0;
        ACK_I  = ($urandom_range(0, 1) != 0);
        ERR_I  = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor
  int       mst_cnt, win_cnt, done_cnt, errp_cnt, busy_cnt, viol, first_stb_bad;
  int       exp_first_stb = 0;
  logic [A-1:0] first_rd;
  logic     m_pc = 0, m_ps = 0, m_seen = 0;
  logic [A-1:0] m_pa = '0;
  logic [W-1:0] m_pd = '0;
  int       m_wi = 0;

  initial begin
    forever begin
      @(negedge CLK_I);
      if (WE_O !== CYC_O) viol++;
      if (TGA_O !== (CYC_O ? 2'b01 : 2'b00)) viol++;
      if (MST_O && CYC_O) viol++;
      if (STB_O && !CYC_O) viol++;
      if (CYC_O && m_pc && ADR_O !== m_pa) viol++;
      if (STB_O && m_ps && DAT_O !== m_pd) viol++;
      if (oError && !oDone) viol++;
      if (CYC_O) begin
        if (!m_pc) begin
          win_cnt++;
          m_wi   = 1;
          m_seen = 0;
        end else m_wi++;
        if (STB_O && !m_seen) begin
          m_seen = 1;
          if (exp_first_stb != 0 && m_wi != exp_first_stb) first_stb_bad++;
        end
      end
      if (MST_O) mst_cnt++;
      if (oDone) done_cnt++;
      if (oError) errp_cnt++;
      if (oBusy) begin
        busy_cnt++;
        if (busy_cnt == 1) first_rd = oDataReadAddress;
      end
      m_pc = CYC_O;
      m_ps = STB_O;
      m_pa = ADR_O;
      m_pd = DAT_O;
    end
  end

  task automatic clear_counts();
    mst_cnt = 0; win_cnt = 0; done_cnt = 0; errp_cnt = 0;
    busy_cnt = 0; viol = 0; first_stb_bad = 0; first_rd = '0;
    strobe_no = 0;
    obs_q.delete();
  endtask

  // One transfer: drive it, then compare against the row-level model.
  task automatic run(input logic [A-1:0] src, input logic [A-1:0] dst, input logic [C-1:0] cnt,
                     input int e_at, input bit rnd, input int gmode, input bit restart);
    logic [A+W-1:0] exp_q[$];
    logic [A-1:0]   a;
    logic [3*W-1:0] row;
    bit             stop = 0;
    int             committed = 0;
    int             exp_err = 0;
    int             er = 0, ew = 0;
    int             stall;
    int             exp_busy;

    @(posedge CLK_I);
    #1;
    clear_counts();
    err_at        = e_at;
    rnd_timing    = rnd;
    gnt_mode      = gmode;
    s_dly         = 1;
    exp_first_stb = (gmode == 0) ? 2 : (gmode == 2) ? 7 : 0;
    iSrcAddress   = src;
    iDstAddress   = dst;
    iRowCount     = cnt;
    iStart        = 1'b1;
    for (int cy = 0; cy < 2000 && done_cnt == 0; cy++) begin
      @(posedge CLK_I);
      #1;
      if (restart && cy == 6) begin
        iStart      = 1'b1;
        iSrcAddress = A'($urandom);
        iDstAddress = A'($urandom);
        iRowCount   = C'($urandom_range(1, 5));
      end else iStart = 1'b0;
    end
    iStart = 1'b0;
    check("done_seen", 128'(done_cnt != 0), 128'(1));
    repeat (20) @(posedge CLK_I);
    #1;

    for (int r = 0; r < int'(cnt) && !stop; r++) begin
      a   = A'(src + r);
      row = mem[a[5:0]];
      for (int w = 0; w < 3 && !stop; w++) begin
        if (r * 3 + w == e_at) begin
          stop = 1; exp_err = 1; er = r; ew = w;
        end else exp_q.push_back({A'(dst + r), row[W*(2-w) +: W]});
      end
      if (!stop) committed++;
    end

    check("done_cnt", 128'(done_cnt), 128'(1));
    check("error", 128'(errp_cnt), 128'(exp_err));
    check("commits", 128'(mst_cnt), 128'(committed));
    check("windows", 128'(win_cnt), 128'(committed + exp_err));
    check("nwrites", 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("write%0d", i), 128'(obs_q[i]), 128'(exp_q[i]));
    check("protocol", 128'(viol), 128'(0));
    check("first_stb", 128'(first_stb_bad), 128'(0));
    check("idle", 128'(oBusy), 128'(0));
    if (cnt != 0) begin
      check("rd_first", 128'(first_rd), 128'(src));
      check("rd_final", 128'(oDataReadAddress), 128'(A'(src + committed)));
    end
    if (!rnd && gmode != 1) begin
      stall    = (gmode == 2) ? 5 : 0;
      exp_busy = exp_err ? (13 * er + 3 * ew + 7 + stall * (er + 1))
                         : (13 * int'(cnt) + 1 + stall * int'(cnt));
      check("cycles", 128'(busy_cnt), 128'(exp_busy));
    end
  endtask

  logic [127:0] outs_all;
  assign outs_all = 128'({oDataReadAddress, CYC_O, STB_O, WE_O, ADR_O, DAT_O, TGA_O, MST_O,
                          oBusy, oDone, oError});

  initial begin
    logic [C-1:0] rc;
    int           ea;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[16] = 96'h11111111_22222222_33333333;

    // Reset state
    repeat (3) @(posedge CLK_I);
    #1 check("reset_outs", outs_all, '0);
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);

    run(16'h0010, 16'h0200, 16'd1, -1, 0, 0, 0);
    run(16'h0020, 16'hFFFE, 16'd3, -1, 0, 0, 0);
    run(16'h0030, 16'h0100, 16'd0, -1, 0, 0, 0);
    run(16'h0005, 16'h4000, 16'd2, -1, 0, 2, 0);
    run(16'h0008, 16'h0300, 16'd2, 1, 0, 0, 0);
    run(16'h0011, 16'h0700, 16'd2, -1, 0, 0, 1);
    run(16'hFFFF, 16'h1234, 16'd2, -1, 0, 0, 0);

    // Asynchronous reset in the middle of a strobe
    @(posedge CLK_I);
    #1;
    clear_counts();
    err_at = -1; rnd_timing = 1; gnt_mode = 0;
    iSrcAddress = 16'h0003; iDstAddress = 16'h0900; iRowCount = 16'd2; iStart = 1'b1;
    @(posedge CLK_I);
    #1 iStart = 1'b0;
    for (int i = 0; i < 50 && !STB_O; i++) begin
      @(posedge CLK_I);
      #1;
    end
    check("stb_reached", 128'(STB_O), 128'(1));
    #2 RST_I = 1'b0;
    #1 check("reset_mid_wr", outs_all, '0);
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    done_cnt = 0;
    repeat (6) @(posedge CLK_I);
    #1;
    check("post_reset_busy", 128'(oBusy), 128'(0));
    check("post_reset_done", 128'(done_cnt), 128'(0));
    check("post_reset_cyc", 128'(CYC_O), 128'(0));

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      rc = C'($urandom_range(0, 4));
      ea = (rc != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3 * rc - 1)) : -1;
      run(A'($urandom), ($urandom_range(0, 3) == 0) ? A'(16'hFFFE + $urandom_range(0, 1)) : A'($urandom),
          rc, ea, 1, int'($urandom_range(0, 1)), (rc != 0 && $urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
